// File: rtl/reg_seq.sv
// reg_seq: instruction sequencer driving a 4x8 register file (read, execute, writeback)
module reg_seq (
  input  logic       clk,
  input  logic       RST_N,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  output logic [1:0] DIR_A,
  output logic [1:0] DIR_B,
  output logic [1:0] DIR_WR,
  output logic       EN,
  output logic [7:0] DI,
  input  logic [7:0] DOA,
  input  logic [7:0] DOB,
  input  logic [7:0] ALU_RES,
  output logic       ALU_GO,
  output logic       DONE
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, IMM, WB} state_t;
  state_t state_q, state_d, dec;
  logic [1:0] op_q, op_d, rd_q, rd_d, dir_a_q, dir_a_d, dir_b_q, dir_b_d, dir_wr_q, dir_wr_d;
  logic [7:0] di_q, di_d;
  logic en_q, alu_go_q, done_q, acc, take;
  logic unused_dob;
  assign unused_dob = ^DOB;
  assign INSTR_READY = RST_N && (state_q == IDLE || state_q == IMM || state_q == WB);
  assign acc = INSTR_VALID && INSTR_READY;
  assign take = acc && state_q != IMM;
  // NOP decodes straight back to IDLE, so it never reaches WB
  assign dec = INSTR[7:6] == 2'b10 ? IMM : INSTR[7:6] == 2'b11 ? IDLE : READ;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc ? dec : IDLE;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      IMM:     state_d = acc ? WB : IMM;
      WB:      state_d = acc ? dec : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d     = take ? INSTR[7:6] : op_q;
    rd_d     = take ? INSTR[5:4] : rd_q;
    dir_a_d  = state_d == READ ? INSTR[3:2] : dir_a_q;
    dir_b_d  = state_d == READ ? INSTR[1:0] : dir_b_q;
    dir_wr_d = state_d == WB ? rd_q : dir_wr_q;
    di_d     = state_q == EXEC ? (op_q == 2'b00 ? ALU_RES : DOA) :
               (state_q == IMM && acc) ? INSTR : di_q;
  end
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      dir_a_q  <= '0;
      dir_b_q  <= '0;
      dir_wr_q <= '0;
      di_q     <= '0;
      en_q     <= 1'b0;
      alu_go_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      dir_a_q  <= dir_a_d;
      dir_b_q  <= dir_b_d;
      dir_wr_q <= dir_wr_d;
      di_q     <= di_d;
      en_q     <= state_d == WB;
      alu_go_q <= state_d == EXEC;
      done_q   <= state_d == WB;
    end
  end
  assign DIR_A  = dir_a_q;
  assign DIR_B  = dir_b_q;
  assign DIR_WR = dir_wr_q;
  assign DI     = di_q;
  assign EN     = en_q;
  assign ALU_GO = alu_go_q;
  assign DONE   = done_q;
endmodule

// File: doc/reg_seq.md
# reg_seq

Instruction sequencer that drives the 4×8-bit register file's write and read ports and hands operands to the external ALU. It accepts 8-bit instructions over a valid/ready handshake and decodes register addresses. It issues the read phase (EN=0, DIR_A/DIR_B), forwards the registered DOA/DOB to the ALU, then writes the result back with EN=1/DIR_WR/DI. It sits between the instruction source and the register file, acting as the initiator on every register-file port.

## Interface
- No parameters; data width fixed at 8, register address width fixed at 2.
- clk  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- INSTR  in  8  instruction or immediate byte.
- INSTR_VALID  in  1  INSTR holds a valid byte.
- INSTR_READY  out  1  sequencer accepts INSTR this cycle.
- DIR_A  out  2  register-file read address A.
- DIR_B  out  2  register-file read address B.
- DIR_WR  out  2  register-file write address.
- EN  out  1  register-file write enable; 0 = read cycle.
- DI  out  8  register-file write data.
- DOA  in  8  register-file output A.
- DOB  in  8  register-file output B.
- ALU_RES  in  8  combinational ALU result of DOA/DOB.
- ALU_GO  out  1  operands on DOA/DOB are valid for the ALU this cycle.
- DONE  out  1  one-cycle pulse during the writeback cycle.

## Operation
- Instruction format: [7:6] opcode, [5:4] rd, [3:2] ra, [1:0] rb.
- Opcode 00 ALU: rd ← ALU_RES(ra, rb).
- Opcode 01 MOV: rd ← ra (DOA).
- Opcode 10 LDI: the next accepted byte is the immediate; rd ← immediate. ra and rb are ignored.
- Opcode 11 NOP: accepted and discarded; no write and no DONE.
- A transfer occurs on a rising edge with INSTR_VALID=1 and INSTR_READY=1.
- INSTR_READY=1 in states IDLE, IMM and WB. It is 0 elsewhere and 0 while RST_N=0.
- FSM states and transitions:
  - IDLE: accept ALU/MOV → READ; accept LDI → IMM; accept NOP or no accept → IDLE.
  - READ: EN=0, DIR_A=ra, DIR_B=rb. The register file registers DOA/DOB at the end of this cycle. Next state is EXEC.
  - EXEC: DOA/DOB are valid and ALU_GO=1. At the end of the cycle, DI is captured as ALU_RES (opcode 00) or DOA (opcode 01). Next state is WB.
  - IMM: waits for the immediate byte. On accept, DI ← INSTR and next state is WB. Without an accept the state holds indefinitely with EN=0.
  - WB: EN=1, DIR_WR=rd, DI held, DONE=1. The register file writes at the end of this cycle. A new instruction may be accepted here with the same decode as IDLE; otherwise next state is IDLE.
- EN is 1 only in WB.
- DIR_A/DIR_B keep their last value outside READ.
- DIR_WR and DI keep their last value outside WB.

## Timing
- Reset values: EN=0, DIR_A=DIR_B=DIR_WR=0, DI=0x00, ALU_GO=0, DONE=0, state=IDLE.
- Reset is asynchronous; EN drops immediately on RST_N falling.
- Reset mid-instruction discards the instruction, and no write occurs. This includes reset asserted during WB: EN falls before the edge.
- All outputs except INSTR_READY are flop outputs, stable for the whole state cycle. INSTR_READY is decoded from state.
- ALU/MOV latency: accept edge → READ → EXEC → WB. The write lands at the end of the 3rd cycle after accept.
- Back-to-back ALU/MOV throughput is 1 instruction per 3 cycles when each instruction is accepted in WB.
- LDI: WB follows the immediate accept by 1 cycle.
- Read-after-write: an instruction accepted in WB of a write to register r reads the new value of r. Its READ follows the write edge, so no stall or bypass is needed.
- The ALU path is 1 cycle: ALU_RES is sampled at the end of EXEC, and the ALU must be combinational.

## Test plan
- Reset: pulse RST_N low mid-WB of an ALU instruction → EN=0 asynchronously; after release, state is IDLE, DONE=0, and the target register is unchanged.
- LDI: INSTR 0x90 then 0x5A → one WB cycle with EN=1, DIR_WR=1, DI=0x5A, DONE=1; r1 reads 0x5A.
- MOV: INSTR 0x64 after r1=0x5A → READ with DIR_A=1, EN=0; EXEC with DOA=0x5A; WB with DIR_WR=2, DI=0x5A.
- ALU: INSTR 0x36, with the model returning ALU_RES=0xB4 → ALU_GO high only in EXEC; WB with DIR_WR=3, DI=0xB4.
- Back-to-back with RAW: 0x90/0x11 (r1=0x11), then MOV 0x64 presented during WB → 3-cycle cadence, and r2 receives 0x11.
- NOP and stall: INSTR 0xC0 → no EN, no DONE. LDI 0xA0 with INSTR_VALID low for 5 cycles → state holds in IMM with EN=0; immediate 0x33 then writes r2=0x33.
